// File: rtl/ksa_pkg.sv
// Shared types and defaults for the Kogge-Stone wide-add sequencing stage.
package ksa_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_NWORDS = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } seq_state_e;

    // Word-counter width; never below one bit so the counter always exists.
    function automatic int unsigned cnt_width(input int unsigned nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/ksa_wide_add_seq.sv
// Streams NWORDS word pairs through one external WIDTH-bit adder, chaining the carry
// between words and emitting registered result words on a valid/ready output.
module ksa_wide_add_seq
    import ksa_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned NWORDS = DEF_NWORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,

    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_last,
    output logic             out_cout
);

    localparam int unsigned   CW        = cnt_width(NWORDS);
    localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

    if (NWORDS < 2) begin : g_param_check
        $error("ksa_wide_add_seq: NWORDS must be at least 2");
    end

    seq_state_e    state;
    logic [CW-1:0] word_cnt;
    logic          carry_q;
    logic          accept;
    logic          is_last;

    // flush blocks acceptance so an aborted cycle can never start a new word
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_last  = (word_cnt == LAST_WORD);

    // Word 0 takes the transaction carry-in, so no carry leaks across transactions.
    assign add_a   = in_a;
    assign add_b   = in_b;
    assign add_cin = (state == IDLE) ? in_cin : carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            word_cnt  <= '0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
        end else if (accept) begin
            out_sum   <= add_sum;
            out_valid <= 1'b1;
            carry_q   <= add_cout;
            out_last  <= is_last;
            out_cout  <= is_last & add_cout;
            if (is_last) begin
                word_cnt <= '0;
                state    <= IDLE;
            end else begin
                word_cnt <= word_cnt + CW'(1);
                state    <= BUSY;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
